// File: rtl/fg_dac_writer.sv
// fg_dac_writer: turns generator sample strobes into timed 8-bit parallel DAC
// writes (setup / WR pulse / hold), with a one-deep pending buffer, overrun
// accounting and DAC clear / power-down sequencing.
module fg_dac_writer #(
  parameter int BITWIDTH        = 8,
  parameter int SETUP_CYCLES    = 1,
  parameter int WR_PULSE_CYCLES = 2,
  parameter int HOLD_CYCLES     = 1,
  parameter int CLR_CYCLES      = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic                powerDown_i,
  input  logic                clear_i,
  input  logic                clearOverrun_i,
  input  logic [BITWIDTH-1:0] sample_i,
  input  logic                sampleValid_STRB_i,
  output logic [BITWIDTH-1:0] dac_data_o,
  output logic                dac_wr_n_o,
  output logic                dac_clr_n_o,
  output logic                dac_pd_n_o,
  output logic                busy_o,
  output logic                overrun_o,
  output logic [7:0]          overrunCount_o
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_WR_LOW, S_HOLD, S_CLEAR} state_t;

  // Counters hold "cycles remaining minus one"; zero marks the last cycle.
  localparam logic [7:0] SETUP_LD = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] PULSE_LD = 8'(WR_PULSE_CYCLES - 1);
  localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] CLR_LD   = 8'(CLR_CYCLES - 1);

  state_t              state, nxt;
  logic [7:0]          cnt, cnt_d;
  logic                pend_v, pend_v_d;
  logic [BITWIDTH-1:0] pend, pend_d, data_d;
  logic                clr_req, clr_req_d;
  logic                acc, last, ovr_evt;
  logic                wr_n_d, clr_n_d;

  assign acc    = sampleValid_STRB_i & enable_i & ~powerDown_i;
  assign last   = (cnt == 8'd0);
  assign busy_o = (state != S_IDLE);

  // State, counter, pending buffer and clear-request registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= S_CLEAR;
      cnt     <= CLR_LD;
      pend_v  <= 1'b0;
      pend    <= '0;
      clr_req <= 1'b0;
    end else begin
      state   <= nxt;
      cnt     <= cnt_d;
      pend_v  <= pend_v_d;
      pend    <= pend_d;
      clr_req <= clr_req_d;
    end
  end

  // Next-state, counter reload, pending-buffer and data-bus selection.
  always_comb begin
    nxt       = state;
    cnt_d     = last ? cnt : cnt - 8'd1;
    pend_v_d  = pend_v;
    pend_d    = pend;
    data_d    = dac_data_o;
    ovr_evt   = 1'b0;
    clr_req_d = clr_req | (clear_i & (state inside {S_SETUP, S_WR_LOW, S_HOLD}));
    // Any accepted strobe while busy lands in the pending slot; the
    // end-of-transfer branch below overrides this when it consumes the slot.
    if (state != S_IDLE && acc) begin
      pend_v_d = 1'b1;
      pend_d   = sample_i;
      ovr_evt  = pend_v;
    end
    case (state)
      S_IDLE: begin
        if (clear_i) begin
          nxt   = S_CLEAR;
          cnt_d = CLR_LD;
          if (acc) begin
            pend_v_d = 1'b1;
            pend_d   = sample_i;
          end
        end else if (acc) begin
          nxt    = S_SETUP;
          cnt_d  = SETUP_LD;
          data_d = sample_i;
        end
      end
      S_SETUP:  if (last) begin nxt = S_WR_LOW; cnt_d = PULSE_LD; end
      S_WR_LOW: if (last) begin nxt = S_HOLD;   cnt_d = HOLD_LD;  end
      S_HOLD, S_CLEAR: begin
        if (last) begin
          if (state == S_HOLD && (clr_req || clear_i)) begin
            nxt   = S_CLEAR;
            cnt_d = CLR_LD;
          end else if (pend_v) begin
            // Pending sample starts now; a simultaneous strobe refills the slot.
            nxt      = S_SETUP;
            cnt_d    = SETUP_LD;
            data_d   = pend;
            pend_v_d = acc;
            ovr_evt  = 1'b0;
          end else if (acc) begin
            nxt      = S_SETUP;
            cnt_d    = SETUP_LD;
            data_d   = sample_i;
            pend_v_d = 1'b0;
            ovr_evt  = 1'b0;
          end else begin
            nxt = S_IDLE;
          end
        end
      end
      default: nxt = S_IDLE;
    endcase
    if (nxt == S_CLEAR) clr_req_d = 1'b0;
  end

  // DAC strobes follow the state being entered so the pins are registered.
  always_comb begin
    wr_n_d  = (nxt != S_WR_LOW);
    clr_n_d = (nxt != S_CLEAR);
  end

  // Registered DAC pins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dac_data_o  <= '0;
      dac_wr_n_o  <= 1'b1;
      dac_clr_n_o <= 1'b0;
      dac_pd_n_o  <= 1'b1;
    end else begin
      dac_data_o  <= data_d;
      dac_wr_n_o  <= wr_n_d;
      dac_clr_n_o <= clr_n_d;
      dac_pd_n_o  <= ~powerDown_i;
    end
  end

  // Sticky overrun flag and saturating count; a new overrun beats a clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overrun_o      <= 1'b0;
      overrunCount_o <= 8'd0;
    end else if (ovr_evt) begin
      overrun_o      <= 1'b1;
      overrunCount_o <= clearOverrun_i ? 8'd1 :
                        (overrunCount_o == 8'hFF) ? 8'hFF : overrunCount_o + 8'd1;
    end else if (clearOverrun_i) begin
      overrun_o      <= 1'b0;
      overrunCount_o <= 8'd0;
    end
  end

endmodule

// File: doc/fg_dac_writer.md
Name: fg_dac_writer

Overview:
Downstream neighbour of the function generator core. It takes each generated sample and its one-cycle valid strobe and drives an 8-bit parallel DAC write with programmable data setup, WR pulse width and hold. A one-entry pending buffer absorbs samples that arrive mid-transfer, and overruns are counted. It also sequences the DAC clear and power-down pins, including a clear pulse after reset.

Parameters:
BITWIDTH, 8, sample and DAC data width.
SETUP_CYCLES, 1, cycles data is stable with WR high before the WR low pulse (range 1..255).
WR_PULSE_CYCLES, 2, WR low pulse width in cycles (range 1..255; 2 cycles = 40 ns at 50 MHz).
HOLD_CYCLES, 1, cycles data stays stable with WR high after the pulse (range 1..255).
CLR_CYCLES, 4, length of the DAC clear pulse in cycles (range 1..255).

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  synchronous reset, active-high.
enable_i  in  1  when low, sample strobes are ignored.
powerDown_i  in  1  DAC power-down request; when high, strobes are ignored.
clear_i  in  1  one-cycle request for a DAC clear pulse.
clearOverrun_i  in  1  clears overrun_o and overrunCount_o.
sample_i  in  BITWIDTH  sample from the generator.
sampleValid_STRB_i  in  1  one-cycle strobe qualifying sample_i.
dac_data_o  out  BITWIDTH  DAC data bus (registered).
dac_wr_n_o  out  1  DAC write, active-low (registered).
dac_clr_n_o  out  1  DAC clear, active-low (registered).
dac_pd_n_o  out  1  DAC power-down, active-low (registered, equals the previous cycle's NOT powerDown_i).
busy_o  out  1  high in any state other than IDLE.
overrun_o  out  1  sticky flag: a pending sample was overwritten.
overrunCount_o  out  8  saturating overrun count.

Behaviour:
- Clock and reset: one clock, clk_i; reset is synchronous and active-high (rst_i).
- Reset values while rst_i is high: dac_data_o=0, dac_wr_n_o=1, dac_clr_n_o=0, dac_pd_n_o=1, busy_o=1, overrun_o=0, overrunCount_o=0, pending buffer empty, state CLEAR with counter loaded.
- State machine: IDLE, SETUP, WR_LOW, HOLD, CLEAR. Each timed state lasts exactly its parameter's cycle count, using an 8-bit down-counter.
- Accepted strobe: sampleValid_STRB_i=1 and enable_i=1 and powerDown_i=0. Other strobes are dropped silently and not counted as overruns.
- CLEAR: dac_clr_n_o=0 and dac_wr_n_o=1 for CLR_CYCLES cycles, then:
  - SETUP if the pending buffer holds a sample;
  - IDLE otherwise.
  - Entered after reset release, and from IDLE on clear_i.
- IDLE -> SETUP on an accepted strobe at cycle N:
  - dac_data_o=sample_i from N+1; SETUP spans N+1..N+SETUP_CYCLES;
  - WR_LOW follows for WR_PULSE_CYCLES cycles with dac_wr_n_o=0; HOLD follows for HOLD_CYCLES cycles.
  - dac_data_o is constant from N+1 to the end of HOLD.
  - Defaults: data at N+1; wr_n low during N+2 and N+3; HOLD at N+4.
  - Transfer length T = SETUP+PULSE+HOLD = 4 cycles.
- End of HOLD (last HOLD cycle), decided in this priority order:
  1. pending clear request -> CLEAR;
  2. pending buffer full -> load it into dac_data_o next cycle and enter SETUP with no IDLE gap;
  3. otherwise -> IDLE.
- Accepted strobe while not in IDLE: the sample is written into the pending buffer. If the buffer is already full, it is overwritten with the newest sample, overrun_o is set, and overrunCount_o increments, saturating at 255.
- Strobe on the last HOLD cycle with the buffer full: the pending sample is consumed into the new transfer and the strobed sample becomes pending. This is not an overrun.
- Strobe on the last HOLD cycle with the buffer empty: the strobed sample starts the next transfer directly (data valid next cycle).
- clear_i while busy: latched as a pending clear request and serviced after the current transfer's HOLD. The pending sample is kept and transferred after CLEAR. A clear_i that arrives during CLEAR is ignored.
- clear_i in IDLE together with an accepted strobe: CLEAR wins and the sample goes into the pending buffer.
- Overrun clear: clearOverrun_i zeroes overrun_o and overrunCount_o next cycle. If an overrun occurs in the same cycle, the overrun wins: flag=1, count=1.
- dac_wr_n_o is never low outside WR_LOW, and never low while dac_clr_n_o is low.
- Reset mid-transfer: on the next edge, dac_wr_n_o=1, the pending sample and clear request are discarded, and the state becomes CLEAR.
- powerDown_i does not abort an in-flight transfer; it only blocks new strobes.

Test Plan:
- Reset and clear: hold rst_i 3 cycles, then release -> dac_clr_n_o=0 for 4 cycles after release and busy_o=1 throughout, then IDLE with busy_o=0 and dac_wr_n_o=1.
- Single write: strobe sample 0xA5 at cycle N -> dac_data_o=0xA5 at N+1; dac_wr_n_o=0 exactly during N+2 and N+3; busy_o falls at N+5.
- Back-to-back: strobe 0x11 at N and 0x22 at N+2 -> 0x22 goes on the bus at N+5 with no IDLE cycle; its wr_n low pulse is at N+6 and N+7; overrun_o=0.
- Overrun: strobe 0x01 at N, then 0x02 at N+1 and 0x03 at N+2 -> 0x02 is never written, 0x03 is written next, overrun_o=1, overrunCount_o=1. Repeating 300 overruns -> count saturates at 255; clearOverrun_i -> 0.
- Gating and clear: strobe while enable_i=0, and again while powerDown_i=1 -> no transfer. With powerDown_i=1, dac_pd_n_o=0 one cycle later. clear_i during WR_LOW with a sample pending -> CLEAR (clr_n low for 4 cycles) after HOLD, then the pending sample is written.
- Reset mid-pulse: assert rst_i during WR_LOW -> dac_wr_n_o=1 and dac_clr_n_o=0 on the next edge; no write of the pending sample after release.
